// File: rtl/wb_writer_pkg.sv
// Shared constants and entry type for the write-back commit buffer and the register file.
`ifndef WB_DEFINES_SVH
`define WB_DEFINES_SVH
`define Enable   1'b1
`define Disable  1'b0
`define ZeroWord 32'h0000_0000
`endif

package wb_writer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  localparam logic                ENABLE    = `Enable;
  localparam logic                DISABLE   = `Disable;
  localparam logic [WORD_W-1:0]   ZERO_WORD = `ZeroWord;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of the pending write-back entries for one ID read address.
module wb_fwd_match
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0]  entries,
  input  logic [DEPTH-1:0]       valid,
  input  logic [AW-1:0]          head,
  input  logic [REG_ADDR_W-1:0]  raddr,
  output logic                   hit,
  output logic [WORD_W-1:0]      data
);

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = DISABLE;
    data = ZERO_WORD;
    for (int k = 0; k < DEPTH; k++) begin
      automatic logic [AW-1:0] idx = head + AW'(k);
      if (valid[idx] && (raddr != '0) && (entries[idx].rd == raddr)) begin
        hit  = ENABLE;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_writer.sv
// In-order commit buffer owning the register-file write port, with per-port
// forwarding of pending results to ID.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   dclk,
  input  logic                   rst,
  input  logic                   rdy_in,
  input  logic                   valid_MEM_i,
  output logic                   ready_MEM_o,
  input  logic [REG_ADDR_W-1:0]  rd_MEM_i,
  input  logic [WORD_W-1:0]      data_MEM_i,
  output logic                   we_REG_o,
  output logic [REG_ADDR_W-1:0]  waddr_REG_o,
  output logic [WORD_W-1:0]      wdata_REG_o,
  input  logic [REG_ADDR_W-1:0]  raddr1_ID_i,
  output logic                   hit1_ID_o,
  output logic [WORD_W-1:0]      fdata1_ID_o,
  input  logic [REG_ADDR_W-1:0]  raddr2_ID_i,
  output logic                   hit2_ID_o,
  output logic [WORD_W-1:0]      fdata2_ID_o,
  output logic [AW:0]            count_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  wb_entry_t             mem [DEPTH];
  logic [AW-1:0]         head_reg;
  logic [AW-1:0]         tail_reg;
  logic [AW:0]           count_reg;

  logic                  pop;
  logic                  push;
  logic                  store;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  assign pop         = rdy_in && (count_reg != '0);
  // A full buffer still accepts when its head drains on the same edge.
  assign ready_MEM_o = !rst && rdy_in && ((count_reg < FULL) || pop);
  assign push        = valid_MEM_i && ready_MEM_o;
  // x0 results complete the handshake but are never queued.
  assign store       = push && (rd_MEM_i != '0);

  assign we_REG_o    = pop;
  assign waddr_REG_o = pop ? mem[head_reg].rd   : '0;
  assign wdata_REG_o = pop ? mem[head_reg].data : ZERO_WORD;
  assign count_o     = count_reg;

  // A slot is live when its distance from head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] age;
    assign age         = AW'(gi) - head_reg;
    assign valid[gi]   = ({1'b0, age} < count_reg);
    assign entries[gi] = mem[gi];
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (pop)   head_reg <= head_reg + AW'(1);
      if (store) tail_reg <= tail_reg + AW'(1);
      case ({store, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (store) mem[tail_reg] <= {rd_MEM_i, data_MEM_i};
  end

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
    .entries (entries),
    .valid   (valid),
    .head    (head_reg),
    .raddr   (raddr1_ID_i),
    .hit     (hit1_ID_o),
    .data    (fdata1_ID_o)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
    .entries (entries),
    .valid   (valid),
    .head    (head_reg),
    .raddr   (raddr2_ID_i),
    .hit     (hit2_ID_o),
    .data    (fdata2_ID_o)
  );

endmodule
